// File: rtl/nn_pkg.sv
// Shared types and defaults for the activation buffer slice.
package nn_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int MAX_N_DEF  = 32;
  localparam int CNT_W      = 6;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } act_buf_state_t;

  // Clamp a requested element count to the bank depth.
  function automatic cnt_t cnt_min(input cnt_t a, input cnt_t b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/act_bank.sv
// One activation bank: register file, synchronous write, asynchronous read.
// Contents are deliberately not reset; readers gate the output by length.
module act_bank #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int AW     = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Capture one word per enabled edge.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/layer_act_buffer.sv
// Ping-pong activation buffer: loads the external input vector into bank 0,
// streams the read bank to the neuron datapath, captures results into the
// other bank, and swaps banks between layers.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | after reset, nothing loaded, waiting for load_start
//   LOAD    | accepting the external vector into bank 0 (ext_ready=1)
//   RUN     | streaming read bank, capturing results into write bank
//   DONE    | final results exposed for readout, done=1
module layer_act_buffer
  import nn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int MAX_N  = MAX_N_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [5:0]        layer_len,
  input  logic [DATA_W-1:0] ext_data,
  input  logic              ext_valid,
  output logic              ext_ready,
  input  logic              output_shft_en,
  input  logic              output_wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              output_sel,
  input  logic              layer_swap,
  input  logic              tot_complete,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              rd_empty,
  output logic              done,
  output logic              ovf_err
);

  localparam int   AW    = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam cnt_t MAX_C = cnt_t'(MAX_N);

  act_buf_state_t state;
  logic           rd_bank;
  logic           wr_bank;
  cnt_t           rd_ptr;
  cnt_t           wr_ptr;
  cnt_t           rd_len;
  cnt_t           load_len;

  logic              load_hs;
  logic              wr_ok;
  cnt_t              wr_next;
  logic              rd_wrap;
  cnt_t              rd_adv;
  logic              we0;
  logic              we1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;

  assign wr_bank = ~rd_bank;
  assign load_hs = ext_ready & ext_valid;

  // Pointer arithmetic shared by the FSM and the bank ports; a write that
  // coincides with a swap lands first, so the new read length includes it.
  always_comb begin
    wr_ok   = (state == ST_RUN) && output_wr_en && (wr_ptr < MAX_C);
    wr_next = wr_ok ? (wr_ptr + cnt_t'(1)) : wr_ptr;
    rd_wrap = (rd_ptr == (rd_len - cnt_t'(1)));
    if (rd_len == '0)  rd_adv = rd_ptr;
    else if (rd_wrap)  rd_adv = '0;
    else               rd_adv = rd_ptr + cnt_t'(1);
  end

  // Bank port steering: bank 0 takes the external vector during LOAD.
  always_comb begin
    we0    = load_hs || (wr_ok && !wr_bank);
    we1    = wr_ok && wr_bank;
    wdata0 = load_hs ? ext_data : wr_data;
  end

  act_bank #(.DATA_W(DATA_W), .DEPTH(MAX_N), .AW(AW)) u_bank0 (
    .clk   (clk),
    .we    (we0),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wdata0),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rdata0)
  );

  act_bank #(.DATA_W(DATA_W), .DEPTH(MAX_N), .AW(AW)) u_bank1 (
    .clk   (clk),
    .we    (we1),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rdata1)
  );

  assign rd_empty = (rd_len == '0);
  assign rd_last  = !rd_empty && rd_wrap;
  assign rd_data  = rd_empty ? '0 : (rd_bank ? rdata1 : rdata0);

  // Sequencing FSM with all control registers and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rd_bank   <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      rd_len    <= '0;
      load_len  <= '0;
      ovf_err   <= 1'b0;
      done      <= 1'b0;
      ext_ready <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (output_shft_en) rd_ptr <= rd_adv;
          if (load_start && (layer_len != '0)) begin
            state     <= ST_LOAD;
            load_len  <= cnt_min(layer_len, MAX_C);
            wr_ptr    <= '0;
            ovf_err   <= 1'b0;
            done      <= 1'b0;
            ext_ready <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (load_hs) begin
            if (wr_ptr == (load_len - cnt_t'(1))) begin
              state     <= ST_RUN;
              ext_ready <= 1'b0;
              rd_bank   <= 1'b0;
              rd_len    <= load_len;
              rd_ptr    <= '0;
              wr_ptr    <= '0;
            end else begin
              wr_ptr <= wr_ptr + cnt_t'(1);
            end
          end
        end
        ST_RUN: begin
          if (output_wr_en && !wr_ok) ovf_err <= 1'b1;
          if (tot_complete || layer_swap) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            if (tot_complete || output_sel) begin
              rd_bank <= ~rd_bank;
              rd_len  <= wr_next;
            end
            if (tot_complete) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end else begin
            wr_ptr <= wr_next;
            if (output_shft_en) rd_ptr <= rd_adv;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_act_buffer.sv
// Bench for layer_act_buffer: directed scenarios with literal expectations,
// then randomized traffic against a queue-based model of the buffer.
module tb_layer_act_buffer;

  localparam int DW = 16;
  localparam int MN = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0;
  logic [5:0]    layer_len = '0;
  logic [DW-1:0] ext_data = '0;
  logic          ext_valid = 1'b0;
  logic          ext_ready;
  logic          output_shft_en = 1'b0;
  logic          output_wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          output_sel = 1'b0;
  logic          layer_swap = 1'b0;
  logic          tot_complete = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          rd_empty;
  logic          done;
  logic          ovf_err;

  layer_act_buffer #(.DATA_W(DW), .MAX_N(MN)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_start     (load_start),
    .layer_len      (layer_len),
    .ext_data       (ext_data),
    .ext_valid      (ext_valid),
    .ext_ready      (ext_ready),
    .output_shft_en (output_shft_en),
    .output_wr_en   (output_wr_en),
    .wr_data        (wr_data),
    .output_sel     (output_sel),
    .layer_swap     (layer_swap),
    .tot_complete   (tot_complete),
    .rd_data        (rd_data),
    .rd_last        (rd_last),
    .rd_empty       (rd_empty),
    .done           (done),
    .ovf_err        (ovf_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Behavioural model: the read bank and write bank as plain vectors.
  typedef enum {M_IDLE, M_LOAD, M_RUN, M_DONE} mstate_t;
  mstate_t       m_state = M_IDLE;
  logic [DW-1:0] rd_q[$];
  logic [DW-1:0] wr_q[$];
  logic [DW-1:0] ld_q[$];
  int            rd_idx = 0;
  int            load_target = 0;
  bit            m_ovf = 1'b0;
  bit            m_done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    rd_q = {};
    wr_q = {};
    ld_q = {};
    rd_idx = 0;
    m_ovf = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic model_step();
    case (m_state)
      M_IDLE, M_DONE: begin
        if (m_state == M_DONE && output_shft_en && rd_q.size() > 0)
          rd_idx = (rd_idx + 1) % rd_q.size();
        if (load_start && layer_len != 0) begin
          m_state = M_LOAD;
          load_target = (int'(layer_len) < MN) ? int'(layer_len) : MN;
          ld_q = {};
          m_ovf = 1'b0;
          m_done = 1'b0;
        end
      end
      M_LOAD: begin
        if (ext_valid) begin
          ld_q.push_back(ext_data);
          if (ld_q.size() == load_target) begin
            rd_q = ld_q;
            rd_idx = 0;
            wr_q = {};
            m_state = M_RUN;
          end
        end
      end
      M_RUN: begin
        if (output_wr_en) begin
          if (wr_q.size() < MN) wr_q.push_back(wr_data);
          else m_ovf = 1'b1;
        end
        if (tot_complete || layer_swap) begin
          rd_idx = 0;
          if (tot_complete || output_sel) rd_q = wr_q;
          wr_q = {};
          if (tot_complete) begin
            m_state = M_DONE;
            m_done = 1'b1;
          end
        end else if (output_shft_en && rd_q.size() > 0) begin
          rd_idx = (rd_idx + 1) % rd_q.size();
        end
      end
      default: ;
    endcase
  endtask

  // Compare process: every falling edge, DUT outputs against the model.
  logic [DW-1:0] e_data;
  bit            e_empty;
  bit            e_last;
  always @(negedge clk) begin
    if (chk_en) begin
      e_empty = (rd_q.size() == 0);
      e_data  = e_empty ? '0 : rd_q[rd_idx];
      e_last  = !e_empty && (rd_idx == rd_q.size() - 1);
      chk("m_ext_ready", ext_ready, m_state == M_LOAD);
      chk("m_done", done, m_done);
      chk("m_ovf_err", ovf_err, m_ovf);
      chk("m_rd_empty", rd_empty, e_empty);
      chk("m_rd_last", rd_last, e_last);
      if (m_state != M_LOAD) chk("m_rd_data", rd_data, e_data);
    end
  end

  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic clr();
    load_start = 0; ext_valid = 0; output_shft_en = 0; output_wr_en = 0;
    layer_swap = 0; tot_complete = 0; output_sel = 0;
  endtask

  task automatic shift();
    output_shft_en = 1; cyc(); output_shft_en = 0;
  endtask

  task automatic wr(input logic [DW-1:0] d);
    output_wr_en = 1; wr_data = d; cyc(); output_wr_en = 0;
  endtask

  task automatic swp(input logic sel);
    layer_swap = 1; output_sel = sel; cyc(); layer_swap = 0; output_sel = 0;
  endtask

  logic [DW-1:0] vals[4] = '{16'd10, 16'd20, 16'd30, 16'd40};
  int            sw_rate;

  initial begin
    model_reset();
    repeat (2) cyc();
    chk_en = 1'b1;
    chk("rst_rd_empty", rd_empty, 1);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_ext_ready", ext_ready, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    cyc();

    // zero-length load request is ignored
    layer_len = 0; load_start = 1; cyc(); load_start = 0;
    chk("len0_ignored", ext_ready, 0);

    // load 4 elements with valid gaps
    layer_len = 4; load_start = 1; cyc(); load_start = 0;
    chk("load_ready", ext_ready, 1);
    for (int i = 0; i < 4; i++) begin
      ext_valid = 0; cyc();
      ext_valid = 1; ext_data = vals[i]; cyc();
      ext_valid = 0;
    end
    chk("load_ready_drop", ext_ready, 0);
    chk("load_first", rd_data, 10);
    chk("load_not_last", rd_last, 0);

    // read wrap
    shift(); chk("wrap_20", rd_data, 20);
    shift(); chk("wrap_30", rd_data, 30); chk("wrap_30_last", rd_last, 0);
    shift(); chk("wrap_40", rd_data, 40); chk("wrap_40_last", rd_last, 1);
    shift(); chk("wrap_10", rd_data, 10); chk("wrap_10_last", rd_last, 0);

    // layer chain with swap
    wr(7); wr(8); wr(9); swp(1);
    chk("chain_7", rd_data, 7);
    shift(); shift();
    chk("chain_9", rd_data, 9); chk("chain_9_last", rd_last, 1);
    shift(); chk("chain_wrap7", rd_data, 7);

    // re-read: current read bank stays
    wr(11); swp(0);
    chk("reread_7", rd_data, 7);

    // write coincident with swap
    wr(1); wr(2);
    output_wr_en = 1; wr_data = 5; layer_swap = 1; output_sel = 1; cyc(); clr();
    chk("simul_first", rd_data, 1);
    shift(); shift();
    chk("simul_elem2", rd_data, 5); chk("simul_last", rd_last, 1);

    // overflow
    for (int i = 0; i < MN + 2; i++) begin
      wr(DW'(100 + i));
      if (i == MN - 1) chk("ovf_at_max", ovf_err, 0);
      if (i == MN) chk("ovf_set", ovf_err, 1);
    end
    swp(1);
    chk("ovf_first", rd_data, 100);
    repeat (MN - 1) shift();
    chk("ovf_lastval", rd_data, 100 + MN - 1); chk("ovf_last", rd_last, 1);

    // completion
    wr(200); wr(201);
    tot_complete = 1; cyc(); tot_complete = 0;
    chk("done_set", done, 1);
    chk("done_first", rd_data, 200);
    chk("done_ovf_kept", ovf_err, 1);
    shift(); chk("done_walk", rd_data, 201); chk("done_walk_last", rd_last, 1);
    shift(); chk("done_wrap", rd_data, 200);

    // reload from DONE clears flags
    layer_len = 2; load_start = 1; cyc(); load_start = 0;
    chk("reload_ovf_clr", ovf_err, 0);
    chk("reload_done_clr", done, 0);
    ext_valid = 1; ext_data = 3; cyc(); ext_data = 4; cyc(); ext_valid = 0;
    chk("reload_first", rd_data, 3);

    // reset mid-RUN
    rst_n = 0; model_reset(); #1;
    chk("midrst_empty", rd_empty, 1);
    chk("midrst_data", rd_data, 0);
    cyc(); rst_n = 1; cyc();

    // randomized traffic
    for (int ph = 0; ph < 2; ph++) begin
      sw_rate = (ph == 0) ? 25 : 90;
      for (int i = 0; i < 2500; i++) begin
        load_start     = ($urandom_range(0, 19) == 0);
        layer_len      = 6'($urandom_range(0, 40));
        ext_valid      = ($urandom_range(0, 2) != 0);
        ext_data       = DW'($urandom);
        output_shft_en = ($urandom_range(0, 2) == 0);
        output_wr_en   = ($urandom_range(0, 1) == 1);
        wr_data        = DW'($urandom);
        output_sel     = ($urandom_range(0, 1) == 1);
        layer_swap     = ($urandom_range(0, sw_rate - 1) == 0);
        tot_complete   = ($urandom_range(0, 149) == 0);
        if ($urandom_range(0, 499) == 0) begin
          rst_n = 0; model_reset(); cyc(); rst_n = 1;
        end
        cyc();
      end
    end
    clr();
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/layer_act_buffer.md
# layer_act_buffer

Ping-pong activation buffer that sits on the far side of the master control path. It loads the external input vector, then streams layer inputs to the neuron datapath one element per `output_shft_en`. It captures neuron results on `output_wr_en` and swaps banks between layers, so each layer consumes the previous layer's outputs. On `tot_complete` it exposes the final layer's results for readout.

## Interface
- `DATA_W`, 16: activation word width (fixed-point).
- `MAX_N`, 32: entries per bank; must be ≤ 63 (6-bit counts).
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load_start`  in  1  pulse: begin loading the external input vector.
- `layer_len`  in  6  element count of the external vector, sampled on `load_start`.
- `ext_data`  in  DATA_W  external input element.
- `ext_valid`  in  1  `ext_data` valid.
- `ext_ready`  out  1  buffer accepts `ext_data` this cycle.
- `output_shft_en`  in  1  advance the read pointer.
- `output_wr_en`  in  1  write `wr_data` to the write bank.
- `wr_data`  in  DATA_W  neuron result.
- `output_sel`  in  1  sampled on `layer_swap`: 1 = next layer reads previous outputs; 0 = re-read the current read bank.
- `layer_swap`  in  1  pulse: end of layer.
- `tot_complete`  in  1  network finished.
- `rd_data`  out  DATA_W  element at the read pointer.
- `rd_last`  out  1  read pointer is at `rd_len-1`.
- `rd_empty`  out  1  `rd_len == 0`.
- `done`  out  1  in the DONE state.
- `ovf_err`  out  1  sticky: a write was dropped because the bank was full.

## Operation
- States: IDLE, LOAD, RUN, DONE.
- **Reset:**
  - state IDLE; `rd_bank=0`, `wr_bank=1`.
  - `rd_ptr`, `wr_ptr`, `rd_len` all 0; `ovf_err`, `done`, `ext_ready` all 0.
  - Bank contents are not reset; `rd_data` is forced to 0 while `rd_empty`.
- **IDLE / DONE + `load_start`:**
  - If `layer_len == 0`, ignore.
  - Otherwise go to LOAD; `load_len = min(layer_len, MAX_N)`, `wr_ptr=0`, `ovf_err=0`.
  - In DONE, also clear `done`.
- **LOAD:**
  - `ext_ready=1`.
  - Each handshake (`ext_valid & ext_ready`) writes `bank0[wr_ptr]` and increments `wr_ptr`.
  - On the handshake with `wr_ptr == load_len-1`: go to RUN with `rd_bank=0`, `wr_bank=1`, `rd_len=load_len`, `rd_ptr=0`, `wr_ptr=0`.
  - `output_*` and `layer_swap` are ignored in LOAD.
- **RUN:**
  - `output_shft_en`: `rd_ptr = (rd_ptr == rd_len-1) ? 0 : rd_ptr+1`.
  - `output_wr_en`: if `wr_ptr < MAX_N`, write `wr_bank[wr_ptr]` and increment `wr_ptr`; otherwise drop the write and set `ovf_err`.
- **`layer_swap` in RUN:**
  - `output_sel=1`: swap `rd_bank` and `wr_bank`; `rd_len=wr_ptr`.
  - `output_sel=0`: banks unchanged; `rd_len` unchanged.
  - Both cases: `rd_ptr=0`, `wr_ptr=0`.
- **`tot_complete` in RUN:** forced swap (as `output_sel=1`), `rd_ptr=0`, go to DONE, `done=1`. `output_shft_en` still walks the results in DONE.
- **Simultaneous events:**
  - `output_wr_en` with `layer_swap`/`tot_complete`: the write lands first at the old `wr_ptr`; the new `rd_len` is `wr_ptr+1`.
  - `output_shft_en` with swap: swap wins, `rd_ptr=0`.
  - `tot_complete` with `layer_swap`: treated as a single `tot_complete`.
- Arithmetic: pointers and lengths are 6 bits, unsigned; there is no wrap on `wr_ptr`, it saturates at `MAX_N`.

## Timing
- All state, pointers and banks update on `posedge clk`; `rst_n` low forces reset values immediately.
- `rd_data` and `rd_last` are combinational from the registered `rd_bank` and `rd_ptr`. A `output_shft_en` at edge k presents the new element right after edge k.
- Written data is readable at the first edge after the write, i.e. after a swap.
- LOAD of N elements takes N handshake cycles minimum; RUN is entered on the edge of the last handshake.
- `ext_ready` is registered-state based, with no combinational path from `ext_valid`.
- `rst_n` asserted mid-LOAD or mid-RUN: returns to IDLE; partial data is discarded (`rd_len=0`).

## Structure
- Shared package `nn_pkg`: `DATA_W` and `MAX_N` defaults, the state enum `act_buf_state_t` (IDLE, LOAD, RUN, DONE), and the 6-bit count type.
- Sub-module `act_bank`: `MAX_N × DATA_W` register file with one synchronous write port and one asynchronous read port. Instantiated twice; bank select muxes the read and write ports.

## Test plan
- **Load:** `load_start`, `layer_len=4`, feed 10,20,30,40 with `ext_valid` gaps → `ext_ready` drops after the 4th; RUN; `rd_data=10`, `rd_len=4`.
- **Read wrap:** 4 `output_shft_en` pulses → `rd_data` 20,30,40,10; `rd_last=1` only while showing 40.
- **Layer chain:** write 7,8,9, then `layer_swap` with `output_sel=1` → `rd_data=7`, `rd_len=3`, `wr_ptr=0`. `output_sel=0` instead → `rd_data=10` again.
- **Simultaneous write and swap:** `output_wr_en` (`wr_data=5`) and `layer_swap` on the same edge after 2 writes → `rd_len=3`, element 2 = 5.
- **Overflow:** `MAX_N+2` writes → `ovf_err=1` after write `MAX_N+1`, bank holds the first `MAX_N`; `load_start` clears `ovf_err`.
- **Completion and reset:** `tot_complete` → `done=1`, `rd_data` = first result. `rst_n` low mid-RUN → IDLE, `rd_empty=1`, `rd_data=0`.
